// File: rtl/edge_event_unit.sv
// Multi-channel edge detector: synchroniser, optional glitch filter, edge
// qualification per mode, sticky pending flags, saturating event counters.
module edge_event_unit #(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         in,
    input  logic [2*N_CH-1:0]       mode,
    input  logic [N_CH-1:0]         clr,
    input  logic [N_CH-1:0]         cnt_clr,
    input  logic [N_CH-1:0]         irq_en,
    output logic [N_CH-1:0]         level,
    output logic [N_CH-1:0]         pulse,
    output logic [N_CH-1:0]         pending,
    output logic [N_CH*CNT_W-1:0]   count,
    output logic                    irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0]  r_sync [SYNC_STAGES];
    logic [N_CH-1:0]  w_sync_out;
    logic [N_CH-1:0]  w_level;
    logic [N_CH-1:0]  r_prev_level;
    logic [N_CH-1:0]  w_rise;
    logic [N_CH-1:0]  w_fall;
    logic [N_CH-1:0]  w_rise_en;
    logic [N_CH-1:0]  w_fall_en;
    logic [N_CH-1:0]  w_event;
    logic [N_CH-1:0]  r_pulse;
    logic [N_CH-1:0]  r_pending;
    logic [CNT_W-1:0] r_count [N_CH];

    // NOTE: the sync chain is a small flop array, not a RAM, so every stage is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_no_filter
            assign w_level = w_sync_out;
        end else begin : g_filter
            localparam int FW = $clog2(FILTER_CYCLES + 1);
            localparam logic [FW-1:0] LAST = FW'(FILTER_CYCLES - 1);

            logic [FW-1:0]   r_fcnt [N_CH];
            logic [N_CH-1:0] r_level;

            // Level flips on the F-th consecutive cycle of disagreement.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_level <= '0;
                    for (int c = 0; c < N_CH; c++) begin
                        r_fcnt[c] <= '0;
                    end
                end else begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (w_sync_out[c] == r_level[c]) begin
                            r_fcnt[c] <= '0;
                        end else if (r_fcnt[c] == LAST) begin
                            r_level[c] <= w_sync_out[c];
                            r_fcnt[c]  <= '0;
                        end else begin
                            r_fcnt[c] <= r_fcnt[c] + FW'(1);
                        end
                    end
                end
            end

            assign w_level = r_level;
        end
    endgenerate

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_rise_en = '0;
        w_fall_en = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_rise_en[c] = mode[2*c];
            w_fall_en[c] = mode[2*c+1];
        end
    end

    assign w_rise  = w_level & ~r_prev_level;
    assign w_fall  = ~w_level & r_prev_level;
    assign w_event = (w_rise & w_rise_en) | (w_fall & w_fall_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_level <= '0;
            r_pulse      <= '0;
            r_pending    <= '0;
        end else begin
            r_prev_level <= w_level;
            r_pulse      <= w_event;
            r_pending    <= r_pulse | (r_pending & ~clr);
        end
    end

    // A clear coinciding with a pulse still counts that pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                r_count[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (cnt_clr[c]) begin
                    r_count[c] <= r_pulse[c] ? CNT_W'(1) : '0;
                end else if (r_pulse[c] && (r_count[c] != CNT_MAX)) begin
                    r_count[c] <= r_count[c] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int c = 0; c < N_CH; c++) begin
            count[c*CNT_W +: CNT_W] = r_count[c];
        end
    end

    assign level   = w_level;
    assign pulse   = r_pulse;
    assign pending = r_pending;
    assign irq     = |(r_pending & irq_en);

endmodule

// File: tb/tb_edge_event_unit.sv
// Bench for edge_event_unit: two instances (unfiltered/8-bit, filtered/3-bit)
// checked every cycle against a sample-history reference model plus directed cases.
module tb_edge_event_unit;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int HL = 8;

    logic        clk;
    logic        rst;
    logic [3:0]  in_v;
    logic [7:0]  mode_v;
    logic [3:0]  clr_v;
    logic [3:0]  cnt_clr_v;
    logic [3:0]  irq_en_v;

    logic [3:0]  level_a, pulse_a, pending_a;
    logic [31:0] count_a;
    logic        irq_a;
    logic [3:0]  level_b, pulse_b, pending_b;
    logic [11:0] count_b;
    logic        irq_b;

    int n_total = 0;
    int n_bad   = 0;

    edge_event_unit #(.N_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(0), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in(in_v), .mode(mode_v), .clr(clr_v),
        .cnt_clr(cnt_clr_v), .irq_en(irq_en_v), .level(level_a), .pulse(pulse_a),
        .pending(pending_a), .count(count_a), .irq(irq_a)
    );

    edge_event_unit #(.N_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .in(in_v), .mode(mode_v), .clr(clr_v),
        .cnt_clr(cnt_clr_v), .irq_en(irq_en_v), .level(level_b), .pulse(pulse_b),
        .pending(pending_b), .count(count_b), .irq(irq_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: per instance u (0 = unfiltered, 1 = filtered), per channel.
    bit m_smp      [2][N][HL];
    bit m_lvl      [2][N];
    bit m_lvl_prev [2][N];
    bit m_pulse    [2][N];
    bit m_pend     [2][N];
    int m_cnt      [2][N];

    function automatic int fcyc(input int u);
        return (u == 0) ? 0 : 3;
    endfunction

    function automatic int cmax(input int u);
        return (u == 0) ? 255 : 7;
    endfunction

    function automatic int cw(input int u);
        return (u == 0) ? 8 : 3;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int c = 0; c < N; c++) begin
                for (int j = 0; j < HL; j++) m_smp[u][c][j] = 1'b0;
                m_lvl[u][c]      = 1'b0;
                m_lvl_prev[u][c] = 1'b0;
                m_pulse[u][c]    = 1'b0;
                m_pend[u][c]     = 1'b0;
                m_cnt[u][c]      = 0;
            end
        end
    endtask

    // One rising edge: m_smp[..][0] is the input sampled at this edge, so the
    // synchroniser output after this edge is m_smp[S-1].
    task automatic model_step(input int u);
        bit l1, l2, p_old, newl, all_diff, rise, fall;
        for (int c = 0; c < N; c++) begin
            l1    = m_lvl[u][c];
            l2    = m_lvl_prev[u][c];
            p_old = m_pulse[u][c];
            for (int j = HL - 1; j > 0; j--) m_smp[u][c][j] = m_smp[u][c][j-1];
            m_smp[u][c][0] = in_v[c];
            if (fcyc(u) == 0) begin
                newl = m_smp[u][c][S-1];
            end else begin
                all_diff = 1'b1;
                for (int j = 0; j < fcyc(u); j++)
                    if (m_smp[u][c][S+j] == l1) all_diff = 1'b0;
                newl = all_diff ? ~l1 : l1;
            end
            rise = l1 && !l2;
            fall = !l1 && l2;
            m_pulse[u][c] = (rise && mode_v[2*c]) || (fall && mode_v[2*c+1]);
            m_pend[u][c]  = p_old || (m_pend[u][c] && !clr_v[c]);
            if (cnt_clr_v[c])
                m_cnt[u][c] = p_old ? 1 : 0;
            else if (p_old)
                m_cnt[u][c] = (m_cnt[u][c] >= cmax(u)) ? cmax(u) : m_cnt[u][c] + 1;
            m_lvl_prev[u][c] = l1;
            m_lvl[u][c]      = newl;
        end
    endtask

    task automatic compare_unit(input int u, input string pfx,
                                input logic [3:0] g_lvl, input logic [3:0] g_pul,
                                input logic [3:0] g_pnd, input logic [31:0] g_cnt,
                                input logic g_irq);
        logic [3:0]  e_lvl, e_pul, e_pnd;
        logic [31:0] e_cnt;
        e_cnt = '0;
        for (int c = 0; c < N; c++) begin
            e_lvl[c] = m_lvl[u][c];
            e_pul[c] = m_pulse[u][c];
            e_pnd[c] = m_pend[u][c];
            e_cnt    = e_cnt | (32'(m_cnt[u][c]) << (c * cw(u)));
        end
        check({pfx, ".level"},   32'(g_lvl), 32'(e_lvl));
        check({pfx, ".pulse"},   32'(g_pul), 32'(e_pul));
        check({pfx, ".pending"}, 32'(g_pnd), 32'(e_pnd));
        check({pfx, ".count"},   g_cnt,      e_cnt);
        check({pfx, ".irq"},     32'(g_irq), 32'(|(e_pnd & irq_en_v)));
    endtask

    task automatic compare_all();
        compare_unit(0, "A", level_a, pulse_a, pending_a, count_a, irq_a);
        compare_unit(1, "B", level_b, pulse_b, pending_b, 32'(count_b), irq_b);
    endtask

    // Advance one clock; outputs are compared on the falling edge, and the
    // caller drives new inputs right after it returns.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
    endtask

    int npa, npb, rise_t, fall_t, t_a, t_b, n_other;

    initial begin
        rst       = 1'b1;
        in_v      = '0;
        mode_v    = 8'b01_10_11_01;
        clr_v     = '0;
        cnt_clr_v = '0;
        irq_en_v  = 4'hF;
        model_reset();

        // Reset state
        repeat (2) tick();
        check("rst_level_a", 32'(level_a), 0);
        check("rst_count_b", 32'(count_b), 0);
        check("rst_irq_a",   32'(irq_a),   0);
        rst = 1'b0;
        repeat (4) tick();

        // Latency, unfiltered instance, ch0 rise mode
        in_v[0] = 1'b1;
        tick(); check("lat_k0", 32'(pulse_a[0]), 0);
        tick(); check("lat_k1", 32'(pulse_a[0]), 0);
        tick(); check("lat_k2", 32'(pulse_a[0]), 1);
        tick(); check("lat_k3", 32'(pulse_a[0]), 0);
        check("lat_count", 32'(count_a[7:0]), 1);
        check("lat_pend",  32'(pending_a[0]), 1);
        repeat (8) tick();

        // Glitch filter, filtered instance, ch1 both-edge mode
        in_v[1] = 1'b1;
        tick(); tick();
        in_v[1] = 1'b0;
        npb = 0;
        repeat (12) begin
            tick();
            if (pulse_b[1]) npb++;
        end
        check("glitch_short", 32'(npb), 0);
        in_v[1] = 1'b1;
        npb = 0; rise_t = -1; fall_t = -1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t == 5) in_v[1] = 1'b0;
            if (pulse_b[1]) begin
                npb++;
                if (level_b[1]) rise_t = t;
                else            fall_t = t;
            end
        end
        check("glitch_npulse", 32'(npb),    2);
        check("glitch_rise_t", 32'(rise_t), 6);
        check("glitch_fall_t", 32'(fall_t), 11);

        // Mode gating on ch2: fall-only, then off
        for (int ph = 0; ph < 4; ph++) begin
            if (ph == 2) mode_v[5:4] = 2'b00;
            in_v[2] = (ph % 2 == 0);
            npa = 0; npb = 0;
            repeat (10) begin
                tick();
                if (pulse_a[2]) npa++;
                if (pulse_b[2]) npb++;
            end
            check($sformatf("gate_a_ph%0d", ph), 32'(npa), (ph == 1) ? 1 : 0);
            check($sformatf("gate_b_ph%0d", ph), 32'(npb), (ph == 1) ? 1 : 0);
            check($sformatf("gate_lvl_ph%0d", ph), 32'({level_a[2], level_b[2]}),
                  (ph % 2 == 0) ? 3 : 0);
        end
        mode_v[5:4] = 2'b10;

        // Sticky/clear races on ch0 of the unfiltered instance
        clr_v = 4'hF;
        tick();
        clr_v = '0;
        in_v[0] = 1'b0;
        repeat (6) tick();
        in_v[0] = 1'b1;
        tick(); tick(); tick();
        check("race_pulse", 32'(pulse_a[0]), 1);
        clr_v[0]     = 1'b1;
        cnt_clr_v[0] = 1'b1;
        tick();
        clr_v     = '0;
        cnt_clr_v = '0;
        check("race_pend", 32'(pending_a[0]),  1);
        check("race_cnt",  32'(count_a[7:0]),  1);
        irq_en_v = 4'h0;
        #1;
        check("irq_masked", 32'(irq_a), 0);
        irq_en_v = 4'h1;
        #1;
        check("irq_ch0", 32'(irq_a), 1);
        clr_v[0] = 1'b1;
        tick();
        clr_v = '0;
        check("clr_works", 32'(pending_a[0]), 0);
        irq_en_v = 4'hF;

        // Saturation on ch3 (rise mode): 10 events, 3-bit counter holds at 7
        cnt_clr_v = 4'hF;
        tick();
        cnt_clr_v = '0;
        repeat (10) begin
            in_v[3] = 1'b1;
            repeat (6) tick();
            in_v[3] = 1'b0;
            repeat (6) tick();
        end
        check("sat_b", 32'(count_b[11:9]),  7);
        check("sat_a", 32'(count_a[31:24]), 10);

        // Reset mid-filter / mid-pulse, then input held high through release
        in_v = '0;
        repeat (8) tick();
        in_v[0] = 1'b1;
        repeat (3) tick();
        assert_reset();
        check("mid_rst_pulse_a", 32'(pulse_a),   0);
        check("mid_rst_level_b", 32'(level_b),   0);
        check("mid_rst_pend_a",  32'(pending_a), 0);
        check("mid_rst_count_a", count_a,        0);
        check("mid_rst_irq",     32'({irq_a, irq_b}), 0);
        in_v = 4'b1000;
        tick(); tick();
        rst = 1'b0;
        npa = 0; npb = 0; t_a = -1; t_b = -1; n_other = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (pulse_a[3]) begin npa++; t_a = t; end
            if (pulse_b[3]) begin npb++; t_b = t; end
            if ((pulse_a[2:0] | pulse_b[2:0]) != 0) n_other++;
        end
        check("rel_npulse_a", 32'(npa), 1);
        check("rel_npulse_b", 32'(npb), 1);
        check("rel_t_a",      32'(t_a), 3);
        check("rel_t_b",      32'(t_b), 6);
        check("rel_other",    32'(n_other), 0);

        // Randomised traffic against the model
        for (int i = 0; i < 2500; i++) begin
            tick();
            if ($urandom_range(0, 599) == 0) begin
                assert_reset();
                tick();
                rst = 1'b0;
            end
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 4) == 0) in_v[c] = ~in_v[c];
                clr_v[c]     = ($urandom_range(0, 7) == 0);
                cnt_clr_v[c] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 31) == 0) mode_v   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) irq_en_v = 4'($urandom_range(0, 15));
        end
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/edge_event_unit.md
EDGE_EVENT_UNIT -- requirements
Module: edge_event_unit

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- N_CH, 4, number of independent input channels.
- SYNC_STAGES, 2, synchroniser depth, minimum 2.
- FILTER_CYCLES, 0, glitch-filter length in cycles; 0 means the filter is bypassed.
- CNT_W, 8, width of each per-channel event counter.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- in, in, N_CH, asynchronous raw input levels.
- mode, in, 2*N_CH, per-channel detect mode: 00 off, 01 rise, 10 fall, 11 both edges.
- clr, in, N_CH, per-channel pending clear, sampled on the clock.
- cnt_clr, in, N_CH, per-channel counter clear.
- irq_en, in, N_CH, per-channel interrupt enable.
- level, out, N_CH, filtered, synchronised input level.
- pulse, out, N_CH, one-cycle event strobe.
- pending, out, N_CH, sticky event flags.
- count, out, N_CH*CNT_W, per-channel event counters; channel c occupies bits [c*CNT_W +: CNT_W].
- irq, out, 1, equals OR of (pending AND irq_en).

Function
REQ-003 Each channel SHALL pass in[c] through a SYNC_STAGES-deep flop chain before any other use.
REQ-004 With FILTER_CYCLES=0, level[c] SHALL equal the last synchroniser stage.
REQ-005 With FILTER_CYCLES=F>0, level[c] SHALL change only after the synchroniser output has differed from level[c] for F consecutive cycles.
- Any cycle of agreement SHALL reset the per-channel filter counter to 0.
- Pulses shorter than F cycles SHALL never reach level.
REQ-006 A rise SHALL be defined as level 0->1 and a fall as level 1->0, each compared against level registered one cycle earlier.
REQ-007 pulse[c] SHALL be registered and high for exactly one cycle per qualifying edge, where the qualifying edge is selected by mode[c].
REQ-008 Latency SHALL be fixed: an input change sampled at clock edge k and held stable SHALL produce pulse high during the cycle after edge k+SYNC_STAGES+FILTER_CYCLES.
REQ-009 With mode[c]=00, pulse, pending and count for that channel SHALL not change; level and the filter SHALL keep tracking.
REQ-010 A mode change SHALL take effect on the next edge-evaluation cycle; no edge SHALL be reported retroactively.
REQ-011 pending[c] SHALL set on pulse[c] and clear on clr[c].
- When set and clear occur in the same cycle, set SHALL win.
REQ-012 count[c] SHALL increment by 1 on each pulse[c] and saturate at 2^CNT_W-1 (no wrap).
- cnt_clr[c] SHALL set count[c] to 0.
- When cnt_clr[c] and pulse[c] occur in the same cycle, count[c] SHALL become 1.
REQ-013 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be reported in the same cycle.
REQ-014 irq SHALL be combinational from the pending and irq_en registers only, with no path from in.

Reset
REQ-015 While rst is high, the following SHALL hold asynchronously: all synchroniser flops, level, previous-level, filter counters, pulse, pending and count = 0, and irq = 0.
REQ-016 Because level resets to 0, an input held high through reset SHALL produce one rise event at the REQ-008 latency after reset release.
REQ-017 Asserting rst mid-filter or mid-pulse SHALL abort the activity with no residual pulse after release, apart from REQ-016 behaviour.

Verification
REQ-018 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- Latency: N_CH=4, SYNC_STAGES=2, F=0, mode[0]=01; in[0] 0->1 before edge 10 -> pulse[0] high only in the cycle after edge 12; count[0]=1; pending[0]=1.
- Glitch filter: F=3, mode=11; in[1] high for 2 cycles, then low -> no pulse. in[1] high for 5 cycles -> exactly one rise pulse at SYNC_STAGES+3 latency, and one fall pulse after the drop.
- Mode gating: mode[2]=10; toggle in[2] 0->1->0 -> only the fall pulse appears. With mode[2]=00 the same toggle -> no pulse, but level[2] follows.
- Sticky and clear races: clr[0] asserted in the same cycle as pulse[0] -> pending[0] stays 1. cnt_clr[0] in the same cycle as pulse[0] -> count[0]=1. irq_en[0]=0 -> irq=0 despite pending.
- Saturation: CNT_W=3, generate 10 rise events -> count saturates at 7.
- Reset: rst asserted mid-filter -> all outputs 0 immediately. in[3] held high across release with mode[3]=01 -> exactly one rise pulse at the REQ-008 latency.
